// File: rtl/rx_packet_parser.sv
// rx_packet_parser
//   Front end of the Q-table update block. It takes a word-serial packet,
//   checks its length, type and source, and stages the fields. When the
//   packet is good it publishes the fields on stable output registers and
//   pulses `en`. It then serves the known-CH list one entry per `kch_next`
//   until `done` arrives. Bad or self-originated packets are dropped and
//   counted.
//
// Ports
//   clk, rst               clock; asynchronous active-high reset
//   rx_valid/rx_ready      word handshake; a word is taken when both are high
//   rx_word, rx_last       packet word; rx_last marks the final word
//   fPacketType .. fQValue published header/body fields
//   fKnownCH               known-CH entry at the read pointer (0 past the end)
//   fKnownCHCount          number of known-CH entries in the published packet
//   kch_next               advance the known-CH read pointer
//   en                     one-cycle start pulse to the update block
//   done                   update block finished with the published fields
//   drop_count             dropped packets, saturating at 8'hFF
//   busy                   high while a packet is being issued or served
module rx_packet_parser #(
  parameter logic [15:0] NODE_ID = 16'h0001,
  parameter int          MAX_KCH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid,
  output logic        rx_ready,
  input  logic [15:0] rx_word,
  input  logic        rx_last,
  output logic [2:0]  fPacketType,
  output logic [15:0] fSourceID,
  output logic [15:0] fSourceHops,
  output logic [15:0] fClusterID,
  output logic [15:0] fEnergyLeft,
  output logic [15:0] fQValue,
  output logic [15:0] fKnownCH,
  output logic [15:0] fKnownCHCount,
  input  logic        kch_next,
  output logic        en,
  input  logic        done,
  output logic [7:0]  drop_count,
  output logic        busy
);

  localparam int         KW        = (MAX_KCH > 1) ? $clog2(MAX_KCH) : 1;
  localparam logic [7:0] MAX_KCH_B = 8'(MAX_KCH);

  typedef enum logic [2:0] {IDLE, FIELDS, KCH, DROP, ISSUE, WAIT_DONE} state_t;

  state_t      state, stateNext;
  logic        accept, dropInc;
  logic [2:0]  stType;
  logic [7:0]  stKch;
  logic [15:0] staging [5];   // src, hops, cluster, energy, Q
  logic [15:0] kchMem [MAX_KCH];
  logic [2:0]  fi;
  logic [7:0]  ki;
  logic [7:0]  rp, rpAdv;

  // header bits [12:8] are reserved
  logic unusedHdr;
  assign unusedHdr = ^rx_word[12:8];

  assign rx_ready = !rst && (state inside {IDLE, FIELDS, KCH, DROP});
  assign busy     = (state == ISSUE) || (state == WAIT_DONE);
  assign accept   = rx_valid && rx_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    dropInc   = 1'b0;
    // read pointer saturates at the entry count
    rpAdv     = (rp < fKnownCHCount[7:0]) ? rp + 8'd1 : rp;
    case (state)
      IDLE: if (accept) begin
        if (rx_last) begin
          dropInc = 1'b1;
        end else if (rx_word[15:13] == 3'b000 || rx_word[7:0] > MAX_KCH_B) begin
          dropInc   = 1'b1;
          stateNext = DROP;
        end else begin
          stateNext = FIELDS;
        end
      end
      FIELDS: if (accept) begin
        if (fi != 3'd4) begin
          if (rx_last) begin
            dropInc   = 1'b1;
            stateNext = IDLE;
          end
        end else if (stKch == 8'd0) begin
          if (rx_last) stateNext = ISSUE;
          else begin
            dropInc   = 1'b1;
            stateNext = DROP;
          end
        end else if (rx_last) begin
          dropInc   = 1'b1;
          stateNext = IDLE;
        end else begin
          stateNext = KCH;
        end
      end
      KCH: if (accept) begin
        if (ki == stKch - 8'd1) begin
          if (rx_last) stateNext = ISSUE;
          else begin
            dropInc   = 1'b1;
            stateNext = DROP;
          end
        end else if (rx_last) begin
          dropInc   = 1'b1;
          stateNext = IDLE;
        end
      end
      DROP: if (accept && rx_last) stateNext = IDLE;
      ISSUE: begin
        if (staging[0] == NODE_ID) begin
          dropInc   = 1'b1;
          stateNext = IDLE;
        end else begin
          stateNext = WAIT_DONE;
        end
      end
      WAIT_DONE: if (done) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stType        <= '0;
      stKch         <= '0;
      fi            <= '0;
      ki            <= '0;
      rp            <= '0;
      for (int i = 0; i < 5; i++)       staging[i] <= '0;
      for (int i = 0; i < MAX_KCH; i++) kchMem[i]  <= '0;
      fPacketType   <= '0;
      fSourceID     <= '0;
      fSourceHops   <= '0;
      fClusterID    <= '0;
      fEnergyLeft   <= '0;
      fQValue       <= '0;
      fKnownCH      <= '0;
      fKnownCHCount <= '0;
      en            <= 1'b0;
      drop_count    <= '0;
    end else begin
      if (dropInc && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
      case (state)
        IDLE: if (accept) begin
          stType <= rx_word[15:13];
          stKch  <= rx_word[7:0];
          fi     <= '0;
        end
        FIELDS: if (accept) begin
          staging[fi] <= rx_word;
          fi          <= fi + 3'd1;
          ki          <= '0;
        end
        KCH: if (accept) begin
          kchMem[ki[KW-1:0]] <= rx_word;
          ki                 <= ki + 8'd1;
        end
        ISSUE: if (staging[0] != NODE_ID) begin
          // staged fields become visible only here, so they stay frozen
          // while the update block consumes them
          fPacketType   <= stType;
          fSourceID     <= staging[0];
          fSourceHops   <= staging[1];
          fClusterID    <= staging[2];
          fEnergyLeft   <= staging[3];
          fQValue       <= staging[4];
          fKnownCHCount <= {8'd0, stKch};
          fKnownCH      <= (stKch != 8'd0) ? kchMem[0] : '0;
          rp            <= '0;
          en            <= 1'b1;
        end
        WAIT_DONE: begin
          en <= 1'b0;
          // done wins over a simultaneous kch_next
          if (!done && kch_next) begin
            rp       <= rpAdv;
            fKnownCH <= (rpAdv < fKnownCHCount[7:0]) ? kchMem[rpAdv[KW-1:0]] : '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rx_packet_parser.sv
module tb_rx_packet_parser;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_valid, rx_ready, rx_last;
  logic [15:0] rx_word;
  logic [2:0]  fPacketType;
  logic [15:0] fSourceID, fSourceHops, fClusterID, fEnergyLeft, fQValue;
  logic [15:0] fKnownCH, fKnownCHCount;
  logic        kch_next, en, done, busy;
  logic [7:0]  drop_count;

  int vecCnt  = 0;
  int missCnt = 0;
  int enCnt   = 0;
  logic [15:0] pkt [$];

  rx_packet_parser #(.NODE_ID(16'h0001), .MAX_KCH(4)) dut (
    .clk(clk), .rst(rst),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_word(rx_word), .rx_last(rx_last),
    .fPacketType(fPacketType), .fSourceID(fSourceID), .fSourceHops(fSourceHops),
    .fClusterID(fClusterID), .fEnergyLeft(fEnergyLeft), .fQValue(fQValue),
    .fKnownCH(fKnownCH), .fKnownCHCount(fKnownCHCount),
    .kch_next(kch_next), .en(en), .done(done),
    .drop_count(drop_count), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (en) enCnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecCnt++;
    if (obs !== exp) begin
      missCnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  // returns #1 after the edge that accepted the word
  task automatic sendWord(input logic [15:0] w, input logic last);
    int n = 0;
    rx_valid = 1'b1; rx_word = w; rx_last = last;
    while (!rx_ready && n < 50) begin cyc(); n++; end
    if (!rx_ready) chk("accept_timeout", {31'd0, rx_ready}, 32'd1);
    cyc();
    rx_valid = 1'b0; rx_last = 1'b0;
  endtask

  task automatic sendPkt();
    for (int i = 0; i < pkt.size(); i++) sendWord(pkt[i], i == pkt.size() - 1);
  endtask

  task automatic nxt();
    kch_next = 1'b1; cyc(); kch_next = 1'b0;
  endtask

  task automatic finishDone();
    done = 1'b1; cyc(); done = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rx_valid = 1'b0; rx_word = '0; rx_last = 1'b0;
    kch_next = 1'b0; done = 1'b0;
    #12;
    chk("rst_en",    en, 0);
    chk("rst_src",   fSourceID, 0);
    chk("rst_kch",   fKnownCH, 0);
    chk("rst_drop",  drop_count, 0);
    chk("rst_busy",  busy, 0);
    @(negedge clk); rst = 1'b0;
    cyc();
    chk("idle_ready", rx_ready, 1);

    // good packet, two known-CH entries
    pkt = '{16'h2002, 16'h0005, 16'h0003, 16'h0007, 16'h1234, 16'h00AA, 16'h0009, 16'h000C};
    sendPkt();
    chk("issue_en0",   en, 0);
    chk("issue_busy",  busy, 1);
    chk("issue_src0",  fSourceID, 0);
    cyc();
    chk("good_en",     en, 1);
    chk("good_type",   fPacketType, 1);
    chk("good_src",    fSourceID, 16'h0005);
    chk("good_hops",   fSourceHops, 16'h0003);
    chk("good_clu",    fClusterID, 16'h0007);
    chk("good_energy", fEnergyLeft, 16'h1234);
    chk("good_q",      fQValue, 16'h00AA);
    chk("good_cnt",    fKnownCHCount, 2);
    chk("good_kch0",   fKnownCH, 16'h0009);
    chk("good_ready",  rx_ready, 0);
    // next header held on the bus during WAIT_DONE
    rx_valid = 1'b1; rx_word = 16'h2001; rx_last = 1'b0;
    cyc();
    chk("good_en_off", en, 0);
    chk("bp_ready",    rx_ready, 0);
    nxt();
    chk("kch1",        fKnownCH, 16'h000C);
    nxt();
    chk("kch_end",     fKnownCH, 16'h0000);
    nxt();
    chk("kch_sat",     fKnownCH, 16'h0000);
    chk("bp_busy",     busy, 1);
    finishDone();
    chk("done_ready",  rx_ready, 1);
    chk("done_busy",   busy, 0);
    chk("done_hold",   fSourceID, 16'h0005);
    chk("done_en",     en, 0);
    cyc();             // held header taken here
    rx_valid = 1'b0;
    pkt = '{16'h0007, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h00BB};
    sendPkt();
    cyc();
    chk("bp_pkt_en",   en, 1);
    chk("bp_pkt_src",  fSourceID, 16'h0007);
    chk("bp_pkt_cnt",  fKnownCHCount, 1);
    chk("bp_pkt_kch",  fKnownCH, 16'h00BB);
    chk("bp_drop",     drop_count, 0);
    done = 1'b1; kch_next = 1'b1; cyc(); done = 1'b0; kch_next = 1'b0;
    chk("done_wins",   fKnownCH, 16'h00BB);
    chk("en_cnt2",     enCnt, 2);

    // short packet
    pkt = '{16'h2000, 16'h0005, 16'h0003};
    sendPkt(); cyc(); cyc();
    chk("short_drop",  drop_count, 1);
    chk("short_en",    enCnt, 2);
    chk("short_ready", rx_ready, 1);
    chk("short_hold",  fSourceID, 16'h0007);

    // good packet with no known-CH entries
    pkt = '{16'h2000, 16'h0009, 16'h0001, 16'h0002, 16'h0003, 16'h0004};
    sendPkt(); cyc();
    chk("k0_en",       en, 1);
    chk("k0_src",      fSourceID, 16'h0009);
    chk("k0_cnt",      fKnownCHCount, 0);
    chk("k0_kch",      fKnownCH, 0);
    finishDone();

    // overlong known-CH list
    pkt.delete();
    pkt.push_back(16'h2005);
    for (int i = 0; i < 10; i++) pkt.push_back(16'h0100 + 16'(i));
    sendPkt(); cyc(); cyc();
    chk("long_drop",   drop_count, 2);
    chk("long_ready",  rx_ready, 1);

    // type 0
    pkt = '{16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005, 16'h0006, 16'h0007};
    sendPkt(); cyc(); cyc();
    chk("type0_drop",  drop_count, 3);

    // self echo
    pkt = '{16'h2001, 16'h0001, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0055};
    sendPkt(); cyc(); cyc();
    chk("self_drop",   drop_count, 4);
    chk("self_en",     enCnt, 3);
    chk("self_src",    fSourceID, 16'h0009);
    chk("self_kch",    fKnownCH, 0);
    chk("self_busy",   busy, 0);

    // reset mid-KCH
    pkt = '{16'h2002, 16'h0006, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h00CC};
    for (int i = 0; i < pkt.size(); i++) sendWord(pkt[i], 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("mrst_drop",   drop_count, 0);
    chk("mrst_src",    fSourceID, 0);
    chk("mrst_energy", fEnergyLeft, 0);
    chk("mrst_busy",   busy, 0);
    @(negedge clk); rst = 1'b0;
    cyc();
    chk("mrst_ready",  rx_ready, 1);

    // saturation with single-word packets
    for (int i = 0; i < 254; i++) sendWord(16'h2000, 1'b1);
    chk("sat_fe",      drop_count, 8'hFE);
    sendWord(16'h2000, 1'b1);
    chk("sat_ff",      drop_count, 8'hFF);
    sendWord(16'h2000, 1'b1);
    cyc();
    chk("sat_hold",    drop_count, 8'hFF);
    chk("en_total",    enCnt, 3);

    $display("== %0d vectors applied, %0d miscompares ==", vecCnt, missCnt);
    $finish;
  end

endmodule
